// File: rtl/mux_5to1.sv
// mux_5to1: write-back result mux with registered copy and illegal-select flags; MUX5TO1_SEL_ERR_CNT_EN adds o_sel_err_cnt
module mux_5to1 #(
  parameter int DATA_WIDTH = 64,
  parameter int SEL_WIDTH = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_en,
  input  logic [SEL_WIDTH-1:0]  i_control_signal,
  input  logic [DATA_WIDTH-1:0] i_mux_0,
  input  logic [DATA_WIDTH-1:0] i_mux_1,
  input  logic [DATA_WIDTH-1:0] i_mux_2,
  input  logic [DATA_WIDTH-1:0] i_mux_3,
  input  logic [DATA_WIDTH-1:0] i_mux_4,
  output logic [DATA_WIDTH-1:0] o_mux,
  output logic                  o_sel_err,
  output logic [DATA_WIDTH-1:0] o_mux_q,
  output logic                  o_valid_q,
`ifdef MUX5TO1_SEL_ERR_CNT_EN
  output logic                  o_sel_err_sticky,
  output logic [7:0]            o_sel_err_cnt
`else
  output logic                  o_sel_err_sticky
`endif
);
  always_comb begin
    o_sel_err = i_control_signal > SEL_WIDTH'(4);
    o_mux = i_control_signal == SEL_WIDTH'(0) ? i_mux_0 :
            i_control_signal == SEL_WIDTH'(1) ? i_mux_1 :
            i_control_signal == SEL_WIDTH'(2) ? i_mux_2 :
            i_control_signal == SEL_WIDTH'(3) ? i_mux_3 :
            i_control_signal == SEL_WIDTH'(4) ? i_mux_4 : '0;
  end
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      o_mux_q <= '0;
      o_valid_q <= 1'b0;
      o_sel_err_sticky <= 1'b0;
    end else begin
      if (i_en) begin
        o_mux_q <= o_mux;
        o_valid_q <= !o_sel_err;
      end
      if (o_sel_err) o_sel_err_sticky <= 1'b1;
    end
  end
`ifdef MUX5TO1_SEL_ERR_CNT_EN
  always_ff @(posedge i_clk) begin
    if (!i_rstn) o_sel_err_cnt <= '0;
    else if (o_sel_err && o_sel_err_cnt != 8'hff) o_sel_err_cnt <= o_sel_err_cnt + 8'd1;
  end
`endif
endmodule

// File: tb/tb_mux_5to1.sv
// tb_mux_5to1: scoreboard bench for mux_5to1 (counter checks when MUX5TO1_SEL_ERR_CNT_EN is defined)
module tb_mux_5to1;
  localparam int W = 64;
  logic i_clk = 1'b0;
  logic i_rstn, i_en;
  logic [2:0] i_control_signal;
  logic [W-1:0] i_mux_0, i_mux_1, i_mux_2, i_mux_3, i_mux_4;
  logic [W-1:0] o_mux, o_mux_q;
  logic o_sel_err, o_valid_q, o_sel_err_sticky;
`ifdef MUX5TO1_SEL_ERR_CNT_EN
  logic [7:0] o_sel_err_cnt;
`endif
  typedef struct {string tag; logic [W-1:0] exp;} exp_t;
  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  logic [W-1:0] q_m;
  logic v_m, st_m;
  logic [7:0] cnt_m;
  mux_5to1 #(.DATA_WIDTH(W), .SEL_WIDTH(3)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_en(i_en), .i_control_signal(i_control_signal),
    .i_mux_0(i_mux_0), .i_mux_1(i_mux_1), .i_mux_2(i_mux_2), .i_mux_3(i_mux_3), .i_mux_4(i_mux_4),
    .o_mux(o_mux), .o_sel_err(o_sel_err), .o_mux_q(o_mux_q), .o_valid_q(o_valid_q),
`ifdef MUX5TO1_SEL_ERR_CNT_EN
    .o_sel_err_sticky(o_sel_err_sticky), .o_sel_err_cnt(o_sel_err_cnt)
`else
    .o_sel_err_sticky(o_sel_err_sticky)
`endif
  );
  always #5 i_clk = ~i_clk;
  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic push(input string tag, input logic [W-1:0] e);
    exp_t x;
    x.tag = tag;
    x.exp = e;
    sb.push_back(x);
  endtask
  task automatic pop_check(input logic [W-1:0] obs);
    exp_t x;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      x = sb.pop_front();
      check(x.tag, obs, x.exp);
    end
  endtask
  function automatic logic [W-1:0] ref_mux(input logic [2:0] s);
    case (s)
      3'd0: return i_mux_0;
      3'd1: return i_mux_1;
      3'd2: return i_mux_2;
      3'd3: return i_mux_3;
      3'd4: return i_mux_4;
      default: return '0;
    endcase
  endfunction
  task automatic cycle(input logic rstn, input logic en, input logic [2:0] s);
    logic illegal;
    illegal = s > 3'd4;
    i_rstn = rstn;
    i_en = en;
    i_control_signal = s;
    push("o_mux", ref_mux(s));
    push("o_sel_err", {63'd0, illegal});
    #1;
    pop_check(o_mux);
    pop_check({63'd0, o_sel_err});
    if (!rstn) begin
      q_m = '0;
      v_m = 1'b0;
      st_m = 1'b0;
      cnt_m = '0;
    end else begin
      if (en) begin
        q_m = illegal ? '0 : ref_mux(s);
        v_m = !illegal;
      end
      if (illegal) begin
        st_m = 1'b1;
        if (cnt_m != 8'hff) cnt_m = cnt_m + 8'd1;
      end
    end
    push("o_mux_q", q_m);
    push("o_valid_q", {63'd0, v_m});
    push("o_sel_err_sticky", {63'd0, st_m});
`ifdef MUX5TO1_SEL_ERR_CNT_EN
    push("o_sel_err_cnt", {56'd0, cnt_m});
`endif
    @(posedge i_clk);
    #1;
    pop_check(o_mux_q);
    pop_check({63'd0, o_valid_q});
    pop_check({63'd0, o_sel_err_sticky});
`ifdef MUX5TO1_SEL_ERR_CNT_EN
    pop_check({56'd0, o_sel_err_cnt});
`endif
    @(negedge i_clk);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    i_mux_0 = 64'h11;
    i_mux_1 = 64'h22;
    i_mux_2 = 64'h33;
    i_mux_3 = 64'h44;
    i_mux_4 = 64'h55;
    q_m = '0;
    v_m = 1'b0;
    st_m = 1'b0;
    cnt_m = '0;
    cycle(1'b0, 1'b1, 3'd6);
    cycle(1'b0, 1'b0, 3'd0);
    for (int s = 0; s < 5; s++) cycle(1'b1, 1'b1, 3'(s));
    for (int s = 5; s < 8; s++) cycle(1'b1, 1'b0, 3'(s));
    cycle(1'b1, 1'b1, 3'd7);
    cycle(1'b1, 1'b0, 3'd0);
    i_mux_3 = 64'hDEAD_BEEF;
    cycle(1'b1, 1'b1, 3'd3);
    i_mux_3 = 64'h1234_5678_9ABC_DEF0;
    cycle(1'b1, 1'b0, 3'd3);
    cycle(1'b1, 1'b0, 3'd4);
    cycle(1'b0, 1'b1, 3'd6);
    cycle(1'b1, 1'b0, 3'd2);
    cycle(1'b1, 1'b1, 3'd5);
    cycle(1'b1, 1'b1, 3'd1);
    i_mux_1 = 'x;
    i_mux_2 = 64'h1000;
    cycle(1'b1, 1'b1, 3'd2);
    i_mux_1 = 64'h22;
    cycle(1'b0, 1'b0, 3'd0);
    for (int i = 0; i < 300; i++) cycle(1'b1, 1'b0, 3'd7);
    cycle(1'b0, 1'b0, 3'd7);
    cycle(1'b1, 1'b1, 3'd0);
    if (sb.size() != 0) check("scoreboard_leftover", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mux_5to1.md
Name: mux_5to1

Overview:
- Five-input, DATA_WIDTH-bit multiplexer used as the result-select mux in the write-back stage.
- Source mapping: 0 ALU result, 1 load data, 2 PC+4, 3 PC target, 4 extended immediate.
- Provides a zero-latency combinational output o_mux for the register-file write path.
- Also provides a registered copy with valid, plus illegal-select detection for debug and verification.

Parameters:
- DATA_WIDTH, 64, width of every data input and of both data outputs.
- SEL_WIDTH, 3, width of i_control_signal; fixed at 3, and other values are unsupported.

Ports:
- i_clk  input  1  rising-edge clock.
- i_rstn  input  1  synchronous active-low reset, sampled on the rising edge of i_clk.
- i_en  input  1  capture enable for the registered output.
- i_control_signal  input  3  source select.
- i_mux_0  input  DATA_WIDTH  source 0.
- i_mux_1  input  DATA_WIDTH  source 1.
- i_mux_2  input  DATA_WIDTH  source 2.
- i_mux_3  input  DATA_WIDTH  source 3.
- i_mux_4  input  DATA_WIDTH  source 4.
- o_mux  output  DATA_WIDTH  combinational selected value.
- o_sel_err  output  1  combinational: select is 5, 6 or 7.
- o_mux_q  output  DATA_WIDTH  registered selected value.
- o_valid_q  output  1  registered: o_mux_q holds a legal capture.
- o_sel_err_sticky  output  1  sticky illegal-select flag.

Behaviour:
- Combinational path:
  - Select 0..4 drives o_mux with i_mux_0..i_mux_4 respectively, with zero latency.
  - Select 5, 6 or 7 drives o_mux to all zeros and o_sel_err to 1; otherwise o_sel_err is 0.
  - No X propagation from an unselected input: an X on an unselected input never reaches o_mux.
  - Fully combinational: no latches; every output is driven on every path.
- Registered path (rising edge of i_clk):
  - i_rstn = 0: o_mux_q = 0, o_valid_q = 0, o_sel_err_sticky = 0. Reset has priority over i_en.
  - i_en = 1 with a legal select: o_mux_q <= o_mux, o_valid_q <= 1.
  - i_en = 1 with an illegal select: o_mux_q <= 0, o_valid_q <= 0.
  - i_en = 0: o_mux_q and o_valid_q hold their values.
  - Latency: 1 cycle from the inputs to o_mux_q.
- Sticky flag:
  - o_sel_err_sticky sets on any rising edge where o_sel_err = 1, regardless of i_en.
  - It clears only on reset.
  - If reset and an illegal select occur in the same cycle, reset wins (flag = 0).
- Reset asserted mid-operation clears all registered state on the next edge. The combinational outputs are unaffected by reset.
- Widths: all inputs are exactly DATA_WIDTH; no sign or zero extension is performed inside the block.

Optional Feature:
- Macro: MUX5TO1_SEL_ERR_CNT_EN.
- When defined, an extra output o_sel_err_cnt (8 bits) is present:
  - It increments on each rising edge where o_sel_err = 1.
  - It saturates at 255.
  - It resets to 0 under i_rstn = 0.
- When undefined:
  - The port and the counter logic do not exist.
  - All other behaviour is identical.

Test Plan:
- Legal selects: i_mux_0..4 = 64'h11, 64'h22, 64'h33, 64'h44, 64'h55. Sweep select 0..4 -> o_mux = 11, 22, 33, 44, 55 in the same cycle, o_sel_err = 0.
- Illegal selects: select 5, 6, 7 -> o_mux = 0, o_sel_err = 1. After the next edge, o_sel_err_sticky = 1, and it stays 1 after select returns to 0.
- Registered path: i_en = 1, select = 3, i_mux_3 = 64'hDEAD_BEEF -> after 1 edge o_mux_q = 64'hDEAD_BEEF, o_valid_q = 1. Then i_en = 0 and i_mux_3 changes -> o_mux_q holds its value.
- Reset: hold i_rstn = 0 for one edge while i_en = 1 and select = 6 -> o_mux_q = 0, o_valid_q = 0, o_sel_err_sticky = 0 (reset wins). After release, an illegal select sets the sticky flag.
- X isolation: i_mux_1 = X, select = 2, i_mux_2 = 64'h1000 -> o_mux = 64'h1000 with no X.
- With MUX5TO1_SEL_ERR_CNT_EN defined: 300 consecutive cycles at select = 7 -> o_sel_err_cnt = 255, saturated. After reset -> 0.
